// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the FP unit arbiter.
package fp_arb_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
endpackage

// File: rtl/fp_unit_arbiter_if.sv
// Requester-side and FP-unit-side signals of the arbiter, grouped as one bundle.
interface fp_unit_arbiter_if #(parameter int NUM_REQ = 4);
  import fp_arb_pkg::*;
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0][FP_W-1:0] req_a;
  logic [NUM_REQ-1:0][FP_W-1:0] req_b;
  logic [NUM_REQ-1:0]           done;
  logic [FP_W-1:0]              result;
  logic                         err;
  logic [IW-1:0]                owner;
  logic                         arb_busy;
  logic [FP_W-1:0]              fpu_a;
  logic [FP_W-1:0]              fpu_b;
  logic                         fpu_start;
  logic [FP_W-1:0]              fpu_y;
  logic                         fpu_ready;
  logic                         fpu_busy;

  modport slave (
    input  req, req_a, req_b, fpu_y, fpu_ready, fpu_busy,
    output done, result, err, owner, arb_busy, fpu_a, fpu_b, fpu_start
  );

  modport master (
    output req, req_a, req_b, fpu_y, fpu_ready, fpu_busy,
    input  done, result, err, owner, arb_busy, fpu_a, fpu_b, fpu_start
  );
endinterface

// File: rtl/rr_picker.sv
// Round-robin pick: first unmasked request at or after ptr, wrapping. Purely combinational.
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         mask,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       vld
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] cand;
  assign cand = req & ~mask;

  // Scan from the farthest offset down so the nearest hit is the last one written.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand[(int'(ptr) + k) % NUM_REQ]) begin
        vld = 1'b1;
        idx = IW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares one FP unit among NUM_REQ requesters: round-robin grant, operand capture,
// one-cycle start, result/done return, watchdog abort with a quiet-NaN result.
module fp_unit_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input logic             clk,
  input logic             reset,
  fp_unit_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  arb_state_t         state, state_nxt;
  logic [IW-1:0]      win_idx;
  logic               win_vld;
  logic [IW-1:0]      rr_ptr;
  logic [NUM_REQ-1:0] mask;
  logic [CW-1:0]      cnt;
  logic               expire;
  logic               grant;
  logic               start_nxt;
  logic               finish;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req  (bus.req),
    .mask (mask),
    .ptr  (rr_ptr),
    .idx  (win_idx),
    .vld  (win_vld)
  );

  assign expire = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (win_vld) state_nxt = ISSUE;
      ISSUE: if (bus.fpu_start) state_nxt = WAIT;
      WAIT:  if (bus.fpu_ready || expire) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // fpu_start is registered, so the busy check is made on the edge that raises it.
  always_comb begin
    grant     = (state == IDLE) && win_vld;
    start_nxt = (grant || (state == ISSUE && !bus.fpu_start)) && !bus.fpu_busy;
    finish    = (state == WAIT) && (bus.fpu_ready || expire);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.done      <= '0;
      bus.result    <= '0;
      bus.err       <= 1'b0;
      bus.owner     <= '0;
      bus.arb_busy  <= 1'b0;
      bus.fpu_a     <= '0;
      bus.fpu_b     <= '0;
      bus.fpu_start <= 1'b0;
      rr_ptr        <= '0;
      mask          <= '0;
      cnt           <= '0;
    end else begin
      bus.fpu_start <= start_nxt;

      if (grant) begin
        bus.fpu_a    <= bus.req_a[win_idx];
        bus.fpu_b    <= bus.req_b[win_idx];
        bus.owner    <= win_idx;
        bus.arb_busy <= 1'b1;
      end

      // The owner's mask only lives for the first IDLE cycle after its response.
      if (state == IDLE) mask <= '0;

      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CW'(1);

      // A completion arriving on the expiry cycle still counts as a good result.
      if (finish) begin
        bus.done   <= NUM_REQ'(1) << bus.owner;
        bus.result <= bus.fpu_ready ? bus.fpu_y : FP_QNAN;
        bus.err    <= ~bus.fpu_ready;
      end

      if (state == RESP) begin
        bus.done     <= '0;
        bus.result   <= '0;
        bus.err      <= 1'b0;
        bus.arb_busy <= 1'b0;
        mask         <= NUM_REQ'(1) << bus.owner;
        rr_ptr       <= (bus.owner == IW'(NUM_REQ - 1)) ? '0 : bus.owner + IW'(1);
      end
    end
  end
endmodule
